ps2_key_state_tracker: RTL and testbench

Clocked successor to the per-byte PS2 key decoder that drives the piano key vector. It consumes received bytes and the one-cycle valid strobe from PS2_Controller on CLOCK_50 and decodes make, break (F0) and extended (E0) prefixes with a prefix FSM. Break codes release only the addressed key. It maintains a registered key-state vector and held-key count, and buffers press/release events in a parametrised FIFO for MasterFSM and mainStateHandler.

---
 rtl/ps2_key_state_tracker_pkg.sv | 15 +
 rtl/ps2_scancode_lut.sv | 55 +++++
 rtl/ps2_key_state_tracker.sv | 129 ++++++++++++
 tb/tb_ps2_key_state_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_key_state_tracker_pkg.sv
// rtl/ps2_key_state_tracker_pkg.sv - shared constants and prefix FSM encoding for the PS2 key tracker
package ps2_key_state_tracker_pkg;

  localparam int          NUM_KEYBOARD_INPUTS = 29;
  localparam logic [7:0]  PS2_BREAK           = 8'hF0;
  localparam logic [7:0]  PS2_EXTEND          = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } prefix_state_t;

endpackage

// File: rtl/ps2_scancode_lut.sv
// rtl/ps2_scancode_lut.sv - maps a set-2 make code to a piano key index
module ps2_scancode_lut #(
  parameter int NUM_KEYS = 29,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic [7:0]       i_byte,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_index
);

  logic [4:0] w_raw;
  logic       w_raw_hit;

  always_comb begin
    w_raw     = 5'd0;
    w_raw_hit = 1'b1;
    case (i_byte)
      8'h45: w_raw = 5'd0;
      8'h16: w_raw = 5'd1;
      8'h1E: w_raw = 5'd2;
      8'h26: w_raw = 5'd3;
      8'h25: w_raw = 5'd4;
      8'h2E: w_raw = 5'd5;
      8'h36: w_raw = 5'd6;
      8'h3D: w_raw = 5'd7;
      8'h3E: w_raw = 5'd8;
      8'h46: w_raw = 5'd9;
      8'h0E: w_raw = 5'd10;
      8'h4E: w_raw = 5'd11;
      8'h55: w_raw = 5'd12;
      8'h66: w_raw = 5'd13;
      8'h0D: w_raw = 5'd14;
      8'h15: w_raw = 5'd15;
      8'h1D: w_raw = 5'd16;
      8'h24: w_raw = 5'd17;
      8'h2D: w_raw = 5'd18;
      8'h2C: w_raw = 5'd19;
      8'h35: w_raw = 5'd20;
      8'h3C: w_raw = 5'd21;
      8'h43: w_raw = 5'd22;
      8'h44: w_raw = 5'd23;
      8'h4D: w_raw = 5'd24;
      8'h54: w_raw = 5'd25;
      8'h5B: w_raw = 5'd26;
      8'h5D: w_raw = 5'd27;
      8'h29: w_raw = 5'd28;
      default: w_raw_hit = 1'b0;
    endcase
  end

  // Entries beyond a reduced NUM_KEYS are treated as unmapped.
  assign o_hit   = w_raw_hit && (int'(w_raw) < NUM_KEYS);
  assign o_index = IDX_W'(w_raw);

endmodule

// File: rtl/ps2_key_state_tracker.sv
// rtl/ps2_key_state_tracker.sv - prefix FSM, key-state vector, held count and event FIFO
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int NUM_KEYS              = NUM_KEYBOARD_INPUTS,
  parameter int EVENT_FIFO_DEPTH      = 8,
  parameter int PREFIX_TIMEOUT_CYCLES = 1000000
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [7:0]                      ps2_data,
  input  logic                            ps2_data_valid,
  input  logic                            clear_all,
  output logic [NUM_KEYS-1:0]             key_state,
  output logic [$clog2(NUM_KEYS+1)-1:0]   held_count,
  output logic                            event_valid,
  output logic [$clog2(NUM_KEYS)-1:0]     event_key,
  output logic                            event_is_press,
  input  logic                            event_ready,
  output logic                            event_overflow
);

  localparam int IDX_W  = $clog2(NUM_KEYS);
  localparam int HC_W   = $clog2(NUM_KEYS+1);
  localparam int AW     = $clog2(EVENT_FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int TMO_W  = $clog2(PREFIX_TIMEOUT_CYCLES+1);

  prefix_state_t         r_state;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic [NUM_KEYS-1:0]   r_key_state;
  logic [HC_W-1:0]       r_held_count;
  logic [IDX_W:0]        r_mem [EVENT_FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_set;
  logic                  w_clr;
  logic                  w_push;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_acc;

  ps2_scancode_lut #(.NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) u_lut (
    .i_byte  (ps2_data),
    .o_hit   (w_hit),
    .o_index (w_idx)
  );

  always_comb begin
    w_set = ps2_data_valid && (r_state == ST_IDLE)  && w_hit && !r_key_state[w_idx];
    w_clr = ps2_data_valid && (r_state == ST_BREAK) && w_hit &&  r_key_state[w_idx];
  end

  assign w_push     = w_set || w_clr;
  assign w_full     = (r_count == CNT_W'(EVENT_FIFO_DEPTH));
  assign w_pop      = (r_count != '0) && event_ready;
  // A pop frees the slot on the same edge, so a push while full is still accepted.
  assign w_push_acc = w_push && (!w_full || w_pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tmo_cnt    <= '0;
      r_key_state  <= '0;
      r_held_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_all) begin
      r_state      <= ST_IDLE;
      r_tmo_cnt    <= '0;
      r_key_state  <= '0;
      r_held_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      if (ps2_data_valid) begin
        r_tmo_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (ps2_data == PS2_BREAK)       r_state <= ST_BREAK;
            else if (ps2_data == PS2_EXTEND) r_state <= ST_EXT;
          end
          ST_BREAK:  if (ps2_data != PS2_BREAK) r_state <= ST_IDLE;
          ST_EXT:    r_state <= (ps2_data == PS2_BREAK) ? ST_EXT_BREAK : ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_tmo_cnt == TMO_W'(PREFIX_TIMEOUT_CYCLES-1)) begin
          r_state   <= ST_IDLE;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
      end

      if (w_set) begin
        r_key_state[w_idx] <= 1'b1;
        r_held_count       <= r_held_count + HC_W'(1);
      end else if (w_clr) begin
        r_key_state[w_idx] <= 1'b0;
        r_held_count       <= r_held_count - HC_W'(1);
      end

      if (w_push_acc) begin
        r_mem[r_wr_ptr] <= {w_idx, w_set};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_push && !w_push_acc) r_overflow <= 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);
    end
  end

  assign key_state      = r_key_state;
  assign held_count     = r_held_count;
  assign event_valid    = (r_count != '0);
  assign event_key      = event_valid ? r_mem[r_rd_ptr][IDX_W:1] : '0;
  assign event_is_press = event_valid ? r_mem[r_rd_ptr][0] : 1'b0;
  assign event_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// tb/tb_ps2_key_state_tracker.sv - directed self-checking bench for ps2_key_state_tracker
module tb_ps2_key_state_tracker;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_data_valid = 1'b0;
  logic        clear_all = 1'b0;
  logic [28:0] key_state;
  logic [4:0]  held_count;
  logic        event_valid;
  logic [4:0]  event_key;
  logic        event_is_press;
  logic        event_ready = 1'b0;
  logic        event_overflow;

  int total = 0;
  int bad   = 0;

  ps2_key_state_tracker #(
    .NUM_KEYS(29), .EVENT_FIFO_DEPTH(8), .PREFIX_TIMEOUT_CYCLES(16)
  ) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .ps2_data       (ps2_data),
    .ps2_data_valid (ps2_data_valid),
    .clear_all      (clear_all),
    .key_state      (key_state),
    .held_count     (held_count),
    .event_valid    (event_valid),
    .event_key      (event_key),
    .event_is_press (event_is_press),
    .event_ready    (event_ready),
    .event_overflow (event_overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ps2_data       = b;
    ps2_data_valid = 1'b1;
    @(negedge CLOCK_50);
    ps2_data_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input int k, input logic p);
    check({tag, "_valid"}, 32'(event_valid), 32'd1);
    check({tag, "_key"}, 32'(event_key), 32'(k));
    check({tag, "_press"}, 32'(event_is_press), 32'(p));
    event_ready = 1'b1;
    @(negedge CLOCK_50);
    event_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    @(negedge CLOCK_50);
    clear_all = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("rst_keys", 32'(key_state), 32'd0);
    check("rst_held", 32'(held_count), 32'd0);
    check("rst_valid", 32'(event_valid), 32'd0);
    check("rst_ovf", 32'(event_overflow), 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // make then break of key 15
    send(8'h15);
    check("mk15_keys", 32'(key_state), 32'h0000_8000);
    check("mk15_held", 32'(held_count), 32'd1);
    send(8'hF0);
    send(8'h15);
    check("br15_keys", 32'(key_state), 32'd0);
    check("br15_held", 32'(held_count), 32'd0);
    pop_chk("t1_ev0", 15, 1'b1);
    pop_chk("t1_ev1", 15, 1'b0);
    check("t1_empty", 32'(event_valid), 32'd0);

    // unmapped byte, then break of key 1 leaves key 2 alone
    send(8'h1C);
    check("unmapped_keys", 32'(key_state), 32'd0);
    check("unmapped_valid", 32'(event_valid), 32'd0);
    send(8'h16); send(8'h1E); send(8'hF0); send(8'h16);
    check("t2_keys", 32'(key_state), 32'h0000_0004);
    check("t2_held", 32'(held_count), 32'd1);
    pop_chk("t2_ev0", 1, 1'b1);
    pop_chk("t2_ev1", 2, 1'b1);
    pop_chk("t2_ev2", 1, 1'b0);
    check("t2_empty", 32'(event_valid), 32'd0);

    // typematic repeat, then extended break ignored
    send(8'h15); send(8'h15); send(8'h15);
    check("t3_keys", 32'(key_state), 32'h0000_8004);
    check("t3_held", 32'(held_count), 32'd2);
    pop_chk("t3_ev0", 15, 1'b1);
    check("t3_empty", 32'(event_valid), 32'd0);
    send(8'hE0); send(8'hF0); send(8'h15);
    check("ext_keys", 32'(key_state), 32'h0000_8004);
    check("ext_valid", 32'(event_valid), 32'd0);

    // prefix timeout: long gap turns next byte into a make, short gap keeps it a break
    do_clear();
    check("clr_keys", 32'(key_state), 32'd0);
    check("clr_held", 32'(held_count), 32'd0);
    send(8'hF0);
    repeat (20) @(negedge CLOCK_50);
    send(8'h29);
    check("tmo_keys", 32'(key_state), 32'h1000_0000);
    check("tmo_held", 32'(held_count), 32'd1);
    pop_chk("tmo_ev", 28, 1'b1);
    send(8'hF0);
    repeat (4) @(negedge CLOCK_50);
    send(8'h29);
    check("notmo_keys", 32'(key_state), 32'd0);
    pop_chk("notmo_ev", 28, 1'b0);

    // overflow with 9 makes into depth 8
    do_clear();
    send(8'h45); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    send(8'h2E); send(8'h36); send(8'h3D); send(8'h3E);
    check("ovf_keys", 32'(key_state), 32'h0000_01FF);
    check("ovf_held", 32'(held_count), 32'd9);
    check("ovf_flag", 32'(event_overflow), 32'd1);
    ps2_data = 8'h46; ps2_data_valid = 1'b1; event_ready = 1'b1;
    @(negedge CLOCK_50);
    ps2_data_valid = 1'b0; event_ready = 1'b0;
    check("fullpp_keys", 32'(key_state), 32'h0000_03FF);
    check("fullpp_held", 32'(held_count), 32'd10);
    for (int i = 1; i <= 7; i++) pop_chk($sformatf("fullpp_ev%0d", i), i, 1'b1);
    pop_chk("fullpp_ev9", 9, 1'b1);
    check("fullpp_empty", 32'(event_valid), 32'd0);

    // clear_all wins over a same-cycle byte
    do_clear();
    check("ovf_sticky", 32'(event_overflow), 32'd1);
    send(8'h26); send(8'h16);
    check("t6_keys", 32'(key_state), 32'h0000_000A);
    ps2_data = 8'h26; ps2_data_valid = 1'b1; clear_all = 1'b1;
    @(negedge CLOCK_50);
    ps2_data_valid = 1'b0; clear_all = 1'b0;
    check("t6_clr_keys", 32'(key_state), 32'd0);
    check("t6_clr_held", 32'(held_count), 32'd0);
    check("t6_clr_valid", 32'(event_valid), 32'd0);

    // async reset mid-prefix discards the pending break
    send(8'h29);
    send(8'hF0);
    reset = 1'b1;
    #1;
    check("arst_keys", 32'(key_state), 32'd0);
    check("arst_ovf", 32'(event_overflow), 32'd0);
    check("arst_valid", 32'(event_valid), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    send(8'h29);
    check("post_rst_keys", 32'(key_state), 32'h1000_0000);
    pop_chk("post_rst_ev", 28, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
